// File: rtl/temp_filt_pkg.sv
// Shared state encoding and sizing helpers for the temperature moving-average filter.
// Used by temp_avg_filter and temp_filt_ring.
package temp_filt_pkg;

  localparam int STATE_W = 2;

  localparam logic [STATE_W-1:0] ST_EMPTY   = 2'd0;
  localparam logic [STATE_W-1:0] ST_PRELOAD = 2'd1;
  localparam logic [STATE_W-1:0] ST_RUN     = 2'd2;

  // Running sum holds DEPTH full-scale samples without overflow.
  function automatic int sum_width(input int data_w, input int log2_depth);
    return data_w + log2_depth;
  endfunction

  // Half an LSB of the averaged result, giving round-half-up on the shift.
  function automatic int round_offset(input int log2_depth);
    return 1 << (log2_depth - 1);
  endfunction

endpackage

// File: rtl/temp_filt_ring.sv
// Circular sample buffer for the moving-average window: DEPTH x DATA_W registers,
// wrapping write pointer, and the oldest entry (the one about to be overwritten) on a read port.
module temp_filt_ring
  import temp_filt_pkg::*;
#(
  parameter int DATA_W     = 12,
  parameter int LOG2_DEPTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ptr_clr_i,
  input  logic                  wr_en_i,
  input  logic [DATA_W-1:0]     wr_data_i,
  output logic [LOG2_DEPTH-1:0] wptr_o,
  output logic [DATA_W-1:0]     oldest_o
);

  localparam int DEPTH = 1 << LOG2_DEPTH;

  logic [DATA_W-1:0]     mem_q [DEPTH];
  logic [LOG2_DEPTH-1:0] wptr_q;
  logic [LOG2_DEPTH-1:0] wptr_d;

  // Power-of-two depth, so the natural pointer rollover is the modulo wrap.
  always_comb begin
    wptr_d = wptr_q;
    if (ptr_clr_i) begin
      wptr_d = '0;
    end else if (wr_en_i) begin
      wptr_d = wptr_q + LOG2_DEPTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_i && !ptr_clr_i) begin
      mem_q[wptr_q] <= wr_data_i;
    end
  end

  assign wptr_o   = wptr_q;
  assign oldest_o = mem_q[wptr_q];

endmodule

// File: rtl/temp_avg_filter.sv
// Moving-average filter on raw XADC temperature codes; one rounded average per accepted sample.
// Optional input spike clamping is enabled by defining TEMP_FILT_SPIKE_REJECT_EN.
//
// state   | meaning
// EMPTY   | no history; next accepted sample seeds the window
// PRELOAD | copying the seed sample into the remaining entries, input stalled
// RUN     | window full; each accepted sample updates the average
module temp_avg_filter
  import temp_filt_pkg::*;
#(
  parameter int DATA_W     = 12,
  parameter int LOG2_DEPTH = 3,
  parameter int SPIKE_THR  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] sample_i,
  input  logic              sample_valid_i,
  output logic              sample_ready_o,
  input  logic              flush_i,
  output logic [DATA_W-1:0] avg_o,
  output logic              avg_valid_o,
  output logic              primed_o,
  output logic              spike_o
);

  localparam int SUM_W = sum_width(DATA_W, LOG2_DEPTH);
  localparam logic [SUM_W:0] RND_OFS = (SUM_W+1)'(round_offset(LOG2_DEPTH));

  logic [STATE_W-1:0]    state_q, state_d;
  logic [SUM_W-1:0]      sum_q, sum_d;
  logic [DATA_W-1:0]     avg_q, avg_d;
  logic                  avg_vld_q, avg_vld_d;
  logic [DATA_W-1:0]     hold_q, hold_d;
  logic                  spike_d;

  logic                  accept;
  logic                  wr_en;
  logic [DATA_W-1:0]     wr_data;
  logic [LOG2_DEPTH-1:0] wptr;
  logic [DATA_W-1:0]     oldest;

  logic [DATA_W-1:0]     x_eff;
  logic                  spike_hit;
  logic [SUM_W:0]        sum_calc;
  logic [SUM_W-1:0]      sum_nxt;
  logic [SUM_W:0]        rnd_calc;
  logic [DATA_W-1:0]     avg_rnd;

  temp_filt_ring #(
    .DATA_W     (DATA_W),
    .LOG2_DEPTH (LOG2_DEPTH)
  ) u_ring (
    .clk       (clk),
    .rst       (rst),
    .ptr_clr_i (flush_i),
    .wr_en_i   (wr_en),
    .wr_data_i (wr_data),
    .wptr_o    (wptr),
    .oldest_o  (oldest)
  );

  assign sample_ready_o = (state_q != ST_PRELOAD);
  assign primed_o       = (state_q == ST_RUN);
  assign accept         = sample_valid_i && sample_ready_o;

`ifdef TEMP_FILT_SPIKE_REJECT_EN
  localparam logic [DATA_W+1:0] THR_X = (DATA_W+2)'(SPIKE_THR);
  localparam logic [DATA_W+1:0] MAX_X = (DATA_W+2)'((1 << DATA_W) - 1);

  logic [DATA_W+1:0] avg_x, smp_x, hi_lim, lo_lim;
  logic              spike_q;
  logic              unused_clamp;

  // Limits are computed two bits wider so avg_o +/- SPIKE_THR cannot wrap before saturation.
  always_comb begin
    avg_x     = {2'b00, avg_q};
    smp_x     = {2'b00, sample_i};
    hi_lim    = avg_x + THR_X;
    lo_lim    = avg_x - THR_X;
    x_eff     = sample_i;
    spike_hit = 1'b0;
    if (smp_x > hi_lim) begin
      spike_hit = 1'b1;
      x_eff     = (hi_lim > MAX_X) ? '1 : hi_lim[DATA_W-1:0];
    end else if ((smp_x + THR_X) < avg_x) begin
      spike_hit = 1'b1;
      x_eff     = (avg_x > THR_X) ? lo_lim[DATA_W-1:0] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      spike_q <= 1'b0;
    end else begin
      spike_q <= spike_d;
    end
  end

  assign spike_o      = spike_q;
  assign unused_clamp = ^{hi_lim[DATA_W+1:DATA_W], lo_lim[DATA_W+1:DATA_W]};
`else
  logic unused_spike;

  assign x_eff        = sample_i;
  assign spike_hit    = 1'b0;
  assign spike_o      = 1'b0;
  assign unused_spike = ^{spike_d, SPIKE_THR};
`endif

  // Oldest entry never exceeds the sum, so the subtraction cannot go negative.
  assign sum_calc = {1'b0, sum_q} + (SUM_W+1)'(x_eff) - (SUM_W+1)'(oldest);
  assign sum_nxt  = sum_calc[SUM_W-1:0];
  assign rnd_calc = {1'b0, sum_nxt} + RND_OFS;
  assign avg_rnd  = rnd_calc[SUM_W-1:LOG2_DEPTH];

  logic unused_arith;
  assign unused_arith = ^{sum_calc[SUM_W], rnd_calc[SUM_W], rnd_calc[LOG2_DEPTH-1:0]};

  always_comb begin
    state_d   = state_q;
    sum_d     = sum_q;
    avg_d     = avg_q;
    avg_vld_d = 1'b0;
    hold_d    = hold_q;
    spike_d   = 1'b0;
    wr_en     = 1'b0;
    wr_data   = hold_q;

    if (flush_i) begin
      state_d = ST_EMPTY;
      sum_d   = '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            wr_en   = 1'b1;
            wr_data = sample_i;
            sum_d   = {sample_i, {LOG2_DEPTH{1'b0}}};
            hold_d  = sample_i;
            state_d = ST_PRELOAD;
          end
        end
        ST_PRELOAD: begin
          // Write pointer doubles as the preload counter; it wraps to 0 on the last entry.
          wr_en = 1'b1;
          if (&wptr) begin
            avg_d     = hold_q;
            avg_vld_d = 1'b1;
            state_d   = ST_RUN;
          end
        end
        ST_RUN: begin
          if (accept) begin
            wr_en     = 1'b1;
            wr_data   = x_eff;
            sum_d     = sum_nxt;
            avg_d     = avg_rnd;
            avg_vld_d = 1'b1;
            spike_d   = spike_hit;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          sum_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_EMPTY;
      sum_q     <= '0;
      avg_q     <= '0;
      avg_vld_q <= 1'b0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      sum_q     <= sum_d;
      avg_q     <= avg_d;
      avg_vld_q <= avg_vld_d;
      hold_q    <= hold_d;
    end
  end

  assign avg_o       = avg_q;
  assign avg_valid_o = avg_vld_q;

endmodule

// File: tb/tb_temp_avg_filter.sv
// Scoreboard bench for temp_avg_filter: a reference window model pushes expected averages
// (value, spike flag, due cycle) on each acceptance; a negedge monitor pops and compares.
module tb_temp_avg_filter;

  localparam int DATA_W     = 12;
  localparam int LOG2_DEPTH = 3;
  localparam int DEPTH      = 8;
  localparam int SPIKE_THR  = 64;
  localparam int MAX_CODE   = 4095;

  logic              clk = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] sample_i;
  logic              sample_valid_i;
  logic              sample_ready_o;
  logic              flush_i;
  logic [DATA_W-1:0] avg_o;
  logic              avg_valid_o;
  logic              primed_o;
  logic              spike_o;

  always #5 clk = ~clk;

  temp_avg_filter #(
    .DATA_W     (DATA_W),
    .LOG2_DEPTH (LOG2_DEPTH),
    .SPIKE_THR  (SPIKE_THR)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .sample_i       (sample_i),
    .sample_valid_i (sample_valid_i),
    .sample_ready_o (sample_ready_o),
    .flush_i        (flush_i),
    .avg_o          (avg_o),
    .avg_valid_o    (avg_valid_o),
    .primed_o       (primed_o),
    .spike_o        (spike_o)
  );

  typedef struct {
    int unsigned avg;
    int unsigned spike;
    int unsigned due;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned cyc   = 0;
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // Reference model: 0 EMPTY, 1 PRELOAD, 2 RUN
  int m_st   = 0;
  int m_cnt  = 0;
  int m_sum  = 0;
  int m_avg  = 0;
  int m_hold = 0;
  int m_wp   = 0;
  int m_win[DEPTH];
  bit m_known = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (avg_valid_o === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("avg_valid_unexpected", avg_valid_o, 0);
      end else begin
        e = sb_q.pop_front();
        chk("avg_o", avg_o, e.avg);
        chk("avg_latency", cyc, e.due);
        chk("spike_o", spike_o, e.spike);
      end
    end else if (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
      chk("avg_valid_missing", avg_valid_o, 1);
      void'(sb_q.pop_front());
    end
  end

  function automatic void drop_future();
    while (sb_q.size() > 0 && sb_q[$].due > cyc) void'(sb_q.pop_back());
  endfunction

  function automatic int clamp_x(input int x, output int sp);
    int r;
    r  = x;
    sp = 0;
`ifdef TEMP_FILT_SPIKE_REJECT_EN
    if (x > m_avg + SPIKE_THR) begin
      sp = 1;
      r  = (m_avg + SPIKE_THR > MAX_CODE) ? MAX_CODE : m_avg + SPIKE_THR;
    end else if (x < m_avg - SPIKE_THR) begin
      sp = 1;
      r  = (m_avg < SPIKE_THR) ? 0 : m_avg - SPIKE_THR;
    end
`endif
    return r;
  endfunction

  // Drive one cycle of stimulus at a negedge, update the model, advance to the next negedge.
  task automatic put(input int s, input bit v, input bit fl);
    int x;
    int sp;
    exp_t e;
    if (m_known) begin
      chk("sample_ready_o", sample_ready_o, (m_st != 1));
      chk("primed_o", primed_o, (m_st == 2));
    end
    sample_i       = s[DATA_W-1:0];
    sample_valid_i = v;
    flush_i        = fl;
    if (fl) begin
      drop_future();
      m_st = 0;
    end else begin
      case (m_st)
        0: if (v) begin
          for (int i = 0; i < DEPTH; i++) m_win[i] = s;
          m_sum  = s * DEPTH;
          m_hold = s;
          m_cnt  = 1;
          m_st   = 1;
          e = '{avg: s, spike: 0, due: cyc + DEPTH};
          sb_q.push_back(e);
        end
        1: begin
          m_cnt++;
          if (m_cnt == DEPTH) begin
            m_st  = 2;
            m_avg = m_hold;
            m_wp  = 0;
          end
        end
        default: if (v) begin
          x = clamp_x(s, sp);
          m_sum = m_sum + x - m_win[m_wp];
          m_win[m_wp] = x;
          m_wp  = (m_wp + 1) % DEPTH;
          m_avg = (m_sum + DEPTH / 2) / DEPTH;
          e = '{avg: m_avg, spike: sp, due: cyc + 1};
          sb_q.push_back(e);
        end
      endcase
    end
    @(negedge clk);
    sample_valid_i = 1'b0;
    flush_i        = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) put(0, 1'b0, 1'b0);
  endtask

  // Seed the window; keep offering a different sample while stalled, which must be lost.
  task automatic prime(input int s);
    put(s, 1'b1, 1'b0);
    for (int i = 0; i < DEPTH - 1; i++) put(s ^ 12'h5A5, 1'b1, 1'b0);
  endtask

  task automatic do_reset(input int n);
    drop_future();
    rst            = 1'b1;
    sample_valid_i = 1'b0;
    flush_i        = 1'b0;
    repeat (n) @(negedge clk);
    rst     = 1'b0;
    m_st    = 0;
    m_avg   = 0;
    m_sum   = 0;
    m_known = 1'b1;
    chk("rst_sample_ready", sample_ready_o, 1);
    chk("rst_avg_o", avg_o, 0);
    chk("rst_avg_valid", avg_valid_o, 0);
    chk("rst_primed", primed_o, 0);
    chk("rst_spike", spike_o, 0);
  endtask

  initial begin
    rst            = 1'b1;
    sample_i       = '0;
    sample_valid_i = 1'b0;
    flush_i        = 1'b0;
    do_reset(2);

    prime(12'h800);
    idle(1);
    chk("prime_800_avg", avg_o, 12'h800);
    chk("prime_800_primed", primed_o, 1);

    put(0, 1'b0, 1'b1);
    prime(100);
    for (int i = 0; i < 8; i++) put(180, 1'b1, 1'b0);
    chk("step_180_final", avg_o, 180);
    idle(2);

    put(0, 1'b0, 1'b1);
    prime(0);
    put(4, 1'b1, 1'b0);
    chk("round_up_4", avg_o, 1);
    put(0, 1'b0, 1'b1);
    prime(0);
    put(3, 1'b1, 1'b0);
    chk("round_down_3", avg_o, 0);

    put(0, 1'b0, 1'b1);
    prime(12'hFFF);
    for (int i = 0; i < 4; i++) put(12'hFFF, 1'b1, 1'b0);
    chk("max_code", avg_o, 12'hFFF);

    put(500, 1'b1, 1'b1);
    chk("flush_avg_hold", avg_o, 12'hFFF);
    chk("flush_ready", sample_ready_o, 1);
    chk("flush_primed", primed_o, 0);
    prime(12'h200);
    put(12'h240, 1'b1, 1'b0);
    idle(1);

    put(0, 1'b0, 1'b1);
    prime(1000);
    put(2000, 1'b1, 1'b0);
`ifdef TEMP_FILT_SPIKE_REJECT_EN
    chk("spike_avg", avg_o, 1008);
    chk("spike_pulse", spike_o, 1);
`else
    chk("spike_avg", avg_o, 1125);
    chk("spike_pulse", spike_o, 0);
`endif
    idle(2);

    put(0, 1'b0, 1'b1);
    put(12'h555, 1'b1, 1'b0);
    put(0, 1'b1, 1'b0);
    put(0, 1'b1, 1'b0);
    do_reset(1);
    prime(12'h123);
    idle(1);
    chk("reprime_after_rst", avg_o, 12'h123);

    put(0, 1'b0, 1'b1);
    prime($urandom_range(0, MAX_CODE));
    for (int i = 0; i < 80; i++) begin
      put($urandom_range(0, MAX_CODE), ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
    end

    idle(12);
    chk("scoreboard_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/temp_avg_filter.md
# temp_avg_filter

Moving-average filter on raw XADC temperature samples, between the XADC read controller and the raw-to-0.1 °C conversion feeding the cooler controller. It keeps a power-of-two window of recent samples in a circular buffer and maintains a running sum. It emits one rounded average per accepted sample, so the fan loop no longer chases single-conversion noise.

## Interface
- `DATA_W`, 12: sample/average width (raw XADC code).
- `LOG2_DEPTH`, 3: log2 of window depth (DEPTH = 8); legal range 1..6.
- `SPIKE_THR`, 64: max allowed |sample − avg_o| in raw codes; used only with the spike macro.

- `clk`  in  1  system clock; one clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `sample_i`  in  DATA_W  raw temperature code.
- `sample_valid_i`  in  1  sample_i valid; accepted when `sample_valid_i && sample_ready_o` at a rising edge.
- `sample_ready_o`  out  1  filter can accept a sample.
- `flush_i`  in  1  discard history, return to EMPTY.
- `avg_o`  out  DATA_W  filtered average, held between updates.
- `avg_valid_o`  out  1  one-cycle pulse when avg_o updates.
- `primed_o`  out  1  high while in RUN.
- `spike_o`  out  1  one-cycle pulse when an input was clamped (macro only).

## Operation
- States: EMPTY → PRELOAD → RUN. flush_i or rst → EMPTY from any state.
- Reset values: state EMPTY, sum 0, write pointer 0, buffer contents don't-care, avg_o 0, avg_valid_o 0, spike_o 0, primed_o 0, sample_ready_o 1.
- EMPTY: sample_ready_o=1.
  - On acceptance of sample S: entry 0 ← S, sum ← S << LOG2_DEPTH, preload counter ← 1, hold S → PRELOAD.
- PRELOAD: sample_ready_o=0. Samples offered are not accepted; upstream loses them.
  - Each cycle, entry[counter] ← S and counter++.
  - After entry DEPTH−1 is written: avg_o ← S, avg_valid_o pulses, write pointer ← 0 → RUN.
- RUN: sample_ready_o=1, primed_o=1.
  - On acceptance of X: sum_next = sum + X − entry[wptr]; entry[wptr] ← X; wptr wraps modulo DEPTH; sum ← sum_next.
  - avg_o ← (sum_next + 2^(LOG2_DEPTH−1)) >> LOG2_DEPTH, i.e. round half up.
  - Sum register width is DATA_W+LOG2_DEPTH. It never overflows, and the rounded result always fits DATA_W (max code preserved).
- flush_i has priority over a simultaneous acceptance: the sample is dropped and no avg_valid_o is produced. avg_o holds its last value; primed_o drops.
- rst mid-PRELOAD or mid-RUN: all reset values apply on the next cycle.

## Timing
- RUN latency: acceptance at edge t → avg_o/avg_valid_o valid in cycle t+1. Throughput is one sample per clock.
- Priming: acceptance at edge t → sample_ready_o low for DEPTH−1 cycles → avg_valid_o pulse with avg_o=S, DEPTH cycles after t.
- sample_ready_o is decoded from registered state (no combinational path from sample_valid_i).
- flush_i takes effect at the edge it is sampled; sample_ready_o is 1 the following cycle.

## Configuration
- `TEMP_FILT_SPIKE_REJECT_EN` defined: in RUN, an accepted X with |X − avg_o| > SPIKE_THR is clamped to avg_o ± SPIKE_THR, saturated to 0..2^DATA_W−1. The clamped value enters the buffer and sum, and spike_o pulses in the same cycle as avg_valid_o. No clamping occurs in EMPTY/PRELOAD.
- Not defined: X enters unmodified, spike_o tied 0, SPIKE_THR unused.

## Structure
- Package `temp_filt_pkg`:
  - state encoding (EMPTY, PRELOAD, RUN)
  - sum-width function DATA_W+LOG2_DEPTH
  - rounding-offset constant
- Sub-module `temp_filt_ring`: DEPTH×DATA_W register array, write pointer and wrap, read-oldest port. The top keeps the FSM, sum, rounding and spike clamp.

## Test plan
- Prime with 0x800 after reset → sample_ready_o low 7 cycles; avg_valid_o pulses 8 cycles after acceptance with avg_o=0x800; primed_o=1.
- Prime 100, then 8 consecutive samples of 180 → avg_o = 110,120,…,180, one per cycle, each 1 cycle after acceptance.
- Rounding: prime 0, feed 4 → avg_o=1; prime 0, feed 3 → avg_o=0. Prime 0xFFF, feed 0xFFF → avg_o=0xFFF (no overflow).
- flush_i high in the same cycle as a valid RUN sample → no avg_valid_o; next cycle sample_ready_o=1, primed_o=0. The next sample re-primes the window.
- Spike, DEPTH=8, SPIKE_THR=64, primed 1000, feed 2000:
  - with `TEMP_FILT_SPIKE_REJECT_EN` → avg_o=1008, spike_o pulse.
  - without the macro → avg_o=1125, spike_o=0.
- rst asserted mid-PRELOAD → next cycle sample_ready_o=1, avg_o=0, avg_valid_o=0; a subsequent sample 0x123 primes to 0x123.
